// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
//   Bundles the requester bank and downstream sink signals of the round-robin
//   4:1 mux arbiter.
//   master : requester bank + sink side (drives req, inp0..3, out_ready)
//   slave  : arbiter side (drives ack, sel, out_valid, out_data)
//   Signals:
//     req[3:0]        request lines, held until the matching ack
//     inp0..inp3      WIDTH-bit words from requesters 0..3
//     ack[3:0]        one-hot accept pulse back to the requester
//     sel[1:0]        index of the requester whose word is held
//     out_valid       out_data holds a granted word
//     out_ready       sink accepts when out_valid & out_ready
//     out_data        held word
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] inp0;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic [WIDTH-1:0] inp3;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output req, inp0, inp1, inp2, inp3, out_ready,
    input  ack, sel, out_valid, out_data
  );

  modport slave (
    input  req, inp0, inp1, inp2, inp3, out_ready,
    output ack, sel, out_valid, out_data
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 data mux. Picks one of
//   four requesters, registers its word into a valid/ready output stage and
//   pulses ack[sel] when the sink accepts. Back-to-back grants give one word
//   per cycle.
//   Ports:
//     clk    in  clock, all state on posedge
//     rst_n  in  synchronous active-low reset
//     bus    rr_mux_arbiter_if.slave (req/inp0..3/out_ready in,
//            ack/sel/out_valid/out_data out)
module rr_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       sel_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  logic             accept_s;
  logic [3:0]       ack_s;
  logic [3:0]       avail_s;
  logic [1:0]       base_s;
  logic             found_s;
  logic [1:0]       sel_d;
  logic [WIDTH-1:0] data_d;

  // Returns {found, index} of the first set bit of r searching base, base+1, ...
  // Offsets are scanned from the far end so the nearest one is the last to win.
  function automatic logic [2:0] pick_f(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + k[1:0];
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Accept detection, ack decode and arbitration of the next winner.
  always_comb begin
    accept_s = valid_q & bus.out_ready & rst_n;
    ack_s    = 4'b0000;
    if (accept_s) begin
      ack_s[sel_q] = 1'b1;
    end else begin
      ack_s = 4'b0000;
    end
    // The requester being acked still shows req for the word just taken.
    avail_s = bus.req & ~ack_s;
    if (accept_s) begin
      base_s = sel_q + 2'd1;
    end else begin
      base_s = ptr_q;
    end
    {found_s, sel_d} = pick_f(avail_s, base_s);
  end

  // Data mux for the arbitration winner.
  always_comb begin
    case (sel_d)
      2'd0:    data_d = bus.inp0;
      2'd1:    data_d = bus.inp1;
      2'd2:    data_d = bus.inp2;
      2'd3:    data_d = bus.inp3;
      default: data_d = {WIDTH{1'b0}};
    endcase
  end

  // Sequencer FSM: IDLE waits for a request, HOLD presents a word until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_s) begin
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (accept_s) begin
            ptr_q <= sel_q + 2'd1;
            if (found_s) begin
              sel_q   <= sel_d;
              data_q  <= data_d;
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_s;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
//   Directed scenarios plus a randomized run checked against a behavioural
//   round-robin model kept in the bench.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.WIDTH(4)) bus();
  rr_mux_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [3:0] inp [4];
  assign bus.inp0 = inp[0];
  assign bus.inp1 = inp[1];
  assign bus.inp2 = inp[2];
  assign bus.inp3 = inp[3];

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- behavioural reference model ----------------
  logic       m_valid = 1'b0;
  logic [1:0] m_sel = 2'd0;
  logic [1:0] m_ptr = 2'd0;
  logic [3:0] m_data = 4'h0;
  int         m_next;

  // -2: keep holding, -1: nobody to grant, else index of the next grant.
  function automatic int model_winner(logic [3:0] r, logic v, logic rdy, logic [1:0] s, logic [1:0] p);
    int start;
    start = p;
    if (v && rdy) begin
      r[s] = 1'b0;
      start = (int'(s) + 1) % 4;
    end else if (v) begin
      return -2;
    end
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always_comb m_next = model_winner(bus.req, m_valid, bus.out_ready, m_sel, m_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_sel <= 2'd0; m_ptr <= 2'd0; m_data <= 4'h0;
    end else begin
      if (m_valid && bus.out_ready) m_ptr <= 2'((int'(m_sel) + 1) % 4);
      if (m_next >= 0) begin
        m_valid <= 1'b1;
        m_sel   <= 2'(m_next);
        m_data  <= inp[m_next];
      end else if (m_next == -1) begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; bus.req = 4'b0000; bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    rst_n = 1'b0; bus.req = 4'hF; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) inp[i] = 4'($urandom_range(1, 15));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
      n_cmp++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
      n_cmp++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", bus.out_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_first_grant: valid %b sel %0d want 1/0", bus.out_valid, bus.sel); end
    n_cmp++; if (bus.out_data !== inp[0]) begin n_fail++; $display("FAIL reset_first_data: got %h want %h", bus.out_data, inp[0]); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100; inp[2] = 4'hA; bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin n_fail++; $display("FAIL single_latency: valid %b ack %b want 0/0000", bus.out_valid, bus.ack); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'd2) begin n_fail++; $display("FAIL single_grant: valid %b sel %0d want 1/2", bus.out_valid, bus.sel); end
    n_cmp++; if (bus.out_data !== 4'hA) begin n_fail++; $display("FAIL single_data: got %h want a", bus.out_data); end
    n_cmp++; if (bus.ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", bus.ack); end
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin n_fail++; $display("FAIL single_idle: valid %b ack %b want 0/0000", bus.out_valid, bus.ack); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 4; i++) inp[i] = 4'(i * 3 + 1);
    bus.req = 4'hF; bus.out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k > 0) bus.req[k-1] = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'(k)) begin n_fail++; $display("FAIL rotation_sel%0d: valid %b sel %0d want 1/%0d", k, bus.out_valid, bus.sel, k); end
      n_cmp++; if (bus.out_data !== 4'(k * 3 + 1)) begin n_fail++; $display("FAIL rotation_data%0d: got %h want %h", k, bus.out_data, 4'(k * 3 + 1)); end
      n_cmp++; if (bus.ack !== 4'(1 << k)) begin n_fail++; $display("FAIL rotation_ack%0d: got %b want %b", k, bus.ack, 4'(1 << k)); end
    end
    tick();
    bus.req[3] = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rotation_end: valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req = 4'b0010; inp[1] = 4'h5; bus.out_ready = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 1) inp[1] = 4'h9;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'd1 || bus.out_data !== 4'h5) begin n_fail++; $display("FAIL backpressure_hold%0d: valid %b sel %0d data %h want 1/1/5", c, bus.out_valid, bus.sel, bus.out_data); end
      n_cmp++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL backpressure_noack%0d: got %b want 0000", c, bus.ack); end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 4'b0010 || bus.out_data !== 4'h5) begin n_fail++; $display("FAIL backpressure_accept: ack %b data %h want 0010/5", bus.ack, bus.out_data); end
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 4'b0000 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_once: ack %b valid %b want 0000/0", bus.ack, bus.out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b1000; inp[3] = 4'hC; inp[0] = 4'h3; bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.sel !== 2'd3 || bus.ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: sel %0d ack %b want 3/1000", bus.sel, bus.ack); end
    tick();
    bus.req = 4'b1001;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_gap: valid %b want 0", bus.out_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.sel !== 2'd0 || bus.out_data !== 4'h3 || bus.ack !== 4'b0001) begin n_fail++; $display("FAIL wrap_ptr: sel %0d data %h ack %b want 0/3/0001", bus.sel, bus.out_data, bus.ack); end
    tick();
    bus.req = 4'b1000;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'd3 || bus.out_data !== 4'hC) begin n_fail++; $display("FAIL wrap_next: valid %b sel %0d data %h want 1/3/c", bus.out_valid, bus.sel, bus.out_data); end
    tick();
    bus.req = 4'b0000;
  endtask

  task automatic test_midreset();
    do_reset();
    bus.req = 4'b0100; inp[2] = 4'h7; bus.out_ready = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'd2) begin n_fail++; $display("FAIL midreset_grant: valid %b sel %0d want 1/2", bus.out_valid, bus.sel); end
    tick();
    rst_n = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL midreset_noack: got %b want 0000", bus.ack); end
    tick();
    rst_n = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.sel !== 2'd0) begin n_fail++; $display("FAIL midreset_cleared: valid %b sel %0d want 0/0", bus.out_valid, bus.sel); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'd2 || bus.out_data !== 4'h7) begin n_fail++; $display("FAIL midreset_regrant: valid %b sel %0d data %h want 1/2/7", bus.out_valid, bus.sel, bus.out_data); end
  endtask

  task automatic test_random();
    bit       pending [4];
    int       waits [4];
    int       acc;
    logic [3:0] exp_ack;
    do_reset();
    for (int i = 0; i < 4; i++) begin pending[i] = 1'b0; waits[i] = 0; end
    acc = -1;
    for (int c = 0; c < 400; c++) begin
      if (acc >= 0) begin
        n_cmp++; if (waits[acc] > 3) begin n_fail++; $display("FAIL random_fairness: requester %0d waited %0d accepts want <=3", acc, waits[acc]); end
        for (int j = 0; j < 4; j++) if (j != acc && pending[j]) waits[j]++;
        pending[acc] = 1'b0;
      end
      for (int j = 0; j < 4; j++) begin
        if (!pending[j] && $urandom_range(0, 2) == 0) begin
          pending[j] = 1'b1; waits[j] = 0; inp[j] = 4'($urandom_range(0, 15));
        end
        bus.req[j] = pending[j];
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_ack = (m_valid && bus.out_ready) ? 4'(1 << m_sel) : 4'b0000;
      n_cmp++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL random_valid c%0d: got %b want %b", c, bus.out_valid, m_valid); end
      n_cmp++; if (bus.sel !== m_sel) begin n_fail++; $display("FAIL random_sel c%0d: got %0d want %0d", c, bus.sel, m_sel); end
      n_cmp++; if (bus.out_data !== m_data) begin n_fail++; $display("FAIL random_data c%0d: got %h want %h", c, bus.out_data, m_data); end
      n_cmp++; if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL random_ack c%0d: got %b want %b", c, bus.ack, exp_ack); end
      acc = (exp_ack != 4'b0000) ? int'(m_sel) : -1;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 4'b0000; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) inp[i] = 4'h0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
